iir_biquad_cascade: RTL and testbench
=====================================

Name: iir_biquad_cascade

Overview:
Programmable cascade of NUM_SECTIONS direct-form-I biquad IIR sections for the SDR receive/transmit filter chain. It is the successor of the single fixed-width 16-bit biquad. Width, Q-format and section count are parametrised, and coefficients are stored in a run-time-writable register file. One time-shared multiply-accumulate unit processes all sections. Samples move in and out through a valid/ready handshake, and saturation is reported.

Parameters:
DATA_W, 16, sample width (signed two's complement)
COEF_W, 16, coefficient width (signed)
COEF_FRAC, 14, coefficient fractional bits (Q2.14 default)
NUM_SECTIONS, 2, cascaded biquads (1..8)
ACC_W, DATA_W+COEF_W+3, accumulator width (derived; not overridden)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  x_in valid
in_ready  out  1  block can accept a sample
x_in  in  DATA_W  input sample
out_valid  out  1  one-cycle pulse, y_out valid
y_out  out  DATA_W  filtered sample, held until next out_valid
cfg_we  in  1  coefficient write strobe
cfg_addr  in  clog2(5*NUM_SECTIONS)  section*5 + tap (0=b0,1=b1,2=b2,3=a1,4=a2)
cfg_wdata  in  COEF_W  coefficient value
cfg_err  out  1  one-cycle pulse: write rejected
clear_state  in  1  zero all delay lines (honoured in IDLE only)
sat_flag  out  1  sticky: any section output saturated

Behaviour:
- Per-section recurrence: y = b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2. Section s input is section s-1 output; section 0 input is x_in.
- Reset values:
  - in_ready=1 after reset releases.
  - out_valid=0, y_out=0, cfg_err=0, sat_flag=0.
  - All delay lines are 0.
  - Coefficients are pass-through: b0=1<<COEF_FRAC; b1, b2, a1, a2 = 0.
- FSM states: IDLE, MAC, STORE, OUT.
  - IDLE: in_ready=1. On in_valid&in_ready, latch x_in, set section=0, tap=0, acc=0, go to MAC.
  - MAC: 5 cycles per section, one product per cycle in tap order b0, b1, b2, a1, a2 (a-terms subtracted). Accumulate at full ACC_W precision; no intermediate saturation.
  - STORE: one cycle.
    - Round half-up: add 1<<(COEF_FRAC-1), then arithmetic-shift right by COEF_FRAC.
    - Saturate to DATA_W; set sat_flag if clipped.
    - Shift the section delay lines: x2<=x1, x1<=x, y2<=y1, y1<=y_sat.
    - If not the last section: go to MAC for the next section, with its input = y_sat. Otherwise go to OUT.
  - OUT: y_out<=final y_sat and out_valid=1 for exactly this cycle, then IDLE.
- Latency: sample accepted at edge k gives out_valid high in cycle k+6*NUM_SECTIONS+1.
- Throughput: one sample per 6*NUM_SECTIONS+2 cycles; in_ready=0 in MAC, STORE and OUT.
- Config writes:
  - Accepted only in IDLE with cfg_addr < 5*NUM_SECTIONS; take effect from the next accepted sample.
  - A write outside IDLE, or to an out-of-range address, is dropped and cfg_err pulses the next cycle.
  - cfg_we and in_valid in the same IDLE cycle: both are accepted; the write applies to that sample only if committed first. Rule: the write is registered that edge and the sample's MAC reads begin the next cycle, so the sample sees the new value.
- clear_state in IDLE zeroes every delay line and clears sat_flag. It is ignored in other states. If asserted together with an accepted sample, the clear happens first and the sample sees zero history.
- rst mid-operation aborts the sample (no out_valid) and restores all reset values, including coefficients.
- Products are COEF_W+DATA_W signed. Sign-extend to ACC_W before accumulating.

Decomposition:
- Package iir_pkg holds:
  - tap index constants TAP_B0..TAP_A2 and TAPS_PER_SECTION=5;
  - the FSM state enum;
  - an ACC_W helper function;
  - the round/saturate constant helpers.
- One sub-module, iir_round_sat: combinational ACC_W-to-DATA_W round-half-up with saturate and a clip output. It is instantiated once, in STORE.

Test Plan:
- Pass-through after reset (NUM_SECTIONS=2): x_in=1000 accepted at cycle 0 -> y_out=1000, out_valid only in cycle 13, sat_flag=0.
- Gain and rounding: write b0=8192 (0.5) to section 0.
  - x=1000 -> 500.
  - x=3 -> 2; x=-3 -> -1 (round half-up).
  - Section 1 left pass-through.
- Recursion: section 0 b0=16384, a1=-8192; impulse 16384 then zeros -> outputs 16384, 8192, 4096, 2048; then clear_state -> next zero input gives 0.
- Saturation: b0=0x7FFF, x=30000 -> y_out=32767 and sat_flag=1 sticky across the following samples. x=-30000 -> -32768.
- Handshake and config guard:
  - in_valid held high for 40 cycles -> exactly 3 samples accepted (period 14).
  - cfg_we during MAC -> cfg_err pulse, coefficient unchanged.
  - cfg_addr=10 in IDLE -> cfg_err.
- Reset mid-operation: rst asserted in cycle 5 of processing -> no out_valid, in_ready=1 after release, and the next x=1000 gives 1000 (pass-through coefficients restored).

Source files
------------

// File: rtl/iir_pkg.sv
// ---------------------------------------------------------------------------
// iir_pkg
// Shared definitions for the biquad cascade: tap numbering inside a section,
// the sequencer state encoding, the derived accumulator width and the
// constants used for coefficient unity and round-half-up.
// ---------------------------------------------------------------------------
package iir_pkg;

  // Coefficients of one section are stored consecutively in this order.
  localparam int         TAPS_PER_SECTION = 5;
  localparam logic [2:0] TAP_B0           = 3'd0;
  localparam logic [2:0] TAP_B1           = 3'd1;
  localparam logic [2:0] TAP_B2           = 3'd2;
  localparam logic [2:0] TAP_A1           = 3'd3;
  localparam logic [2:0] TAP_A2           = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_STORE = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  // Product width plus 3 guard bits: five full-scale products cannot overflow.
  function automatic int acc_width(input int data_w, input int coef_w);
    return data_w + coef_w + 3;
  endfunction

  // Half an output LSB in accumulator scale (round half-up bias).
  function automatic int round_bias(input int frac);
    if (frac > 0) begin
      return 32'sd1 << (frac - 1);
    end else begin
      return 32'sd0;
    end
  endfunction

  // Coefficient value representing 1.0.
  function automatic int coef_unity(input int frac);
    return 32'sd1 << frac;
  endfunction

endpackage

// File: rtl/iir_round_sat.sv
// ---------------------------------------------------------------------------
// iir_round_sat
// Combinational conversion of a full-precision accumulator to an output
// sample: round half-up, arithmetic shift by COEF_FRAC, saturate to DATA_W.
// Ports:
//   acc_i  : signed accumulator, ACC_W bits, COEF_FRAC fractional bits
//   y_o    : signed rounded/saturated sample, DATA_W bits
//   clip_o : high when the rounded value did not fit and was clipped
// ---------------------------------------------------------------------------
module iir_round_sat
  import iir_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int ACC_W     = 35
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic                     clip_o
);

  localparam logic signed [ACC_W-1:0] BIAS  = ACC_W'(round_bias(COEF_FRAC));
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0] biased_s;
  logic signed [ACC_W-1:0] shifted_s;

  // Round, scale back to sample units and clamp to the sample range.
  always_comb begin
    biased_s  = acc_i + BIAS;
    shifted_s = biased_s >>> COEF_FRAC;
    if (shifted_s > Y_MAX) begin
      y_o    = Y_MAX[DATA_W-1:0];
      clip_o = 1'b1;
    end else if (shifted_s < Y_MIN) begin
      y_o    = Y_MIN[DATA_W-1:0];
      clip_o = 1'b1;
    end else begin
      y_o    = shifted_s[DATA_W-1:0];
      clip_o = 1'b0;
    end
  end

endmodule

// File: rtl/iir_biquad_cascade.sv
// ---------------------------------------------------------------------------
// iir_biquad_cascade
// Cascade of NUM_SECTIONS direct-form-I biquads sharing one multiply-
// accumulate unit. Each section takes 5 MAC cycles (b0,b1,b2,a1,a2) plus one
// STORE cycle; one OUT cycle presents the result.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   in_valid/in_ready/x_in : input sample handshake (ready only in IDLE)
//   out_valid/y_out        : one-cycle result pulse, y_out held afterwards
//   cfg_we/addr/wdata      : coefficient write, addr = section*5 + tap
//   cfg_err                : pulse, previous-cycle write was rejected
//   clear_state            : zero all delay lines and sat_flag (IDLE only)
//   sat_flag               : sticky, some section output was clipped
// ---------------------------------------------------------------------------
module iir_biquad_cascade
  import iir_pkg::*;
#(
  parameter  int DATA_W       = 16,
  parameter  int COEF_W       = 16,
  parameter  int COEF_FRAC    = 14,
  parameter  int NUM_SECTIONS = 2,
  localparam int ACC_W        = acc_width(DATA_W, COEF_W),
  localparam int NUM_COEF     = TAPS_PER_SECTION * NUM_SECTIONS,
  localparam int ADDR_W       = $clog2(NUM_COEF)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x_in,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y_out,
  input  logic                     cfg_we,
  input  logic [ADDR_W-1:0]        cfg_addr,
  input  logic signed [COEF_W-1:0] cfg_wdata,
  output logic                     cfg_err,
  input  logic                     clear_state,
  output logic                     sat_flag
);

  localparam int PROD_W = COEF_W + DATA_W;
  localparam int SEC_W  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
  localparam logic [SEC_W-1:0]         LAST_SEC   = SEC_W'(NUM_SECTIONS - 1);
  localparam logic [ADDR_W:0]          NUM_COEF_A = (ADDR_W+1)'(NUM_COEF);
  localparam logic signed [COEF_W-1:0] COEF_ONE   = COEF_W'(coef_unity(COEF_FRAC));

  state_e                   state_q, state_d;
  logic [2:0]               tap_q, tap_d;
  logic [SEC_W-1:0]         sec_q, sec_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] cur_x_q, cur_x_d;
  logic signed [COEF_W-1:0] coef_q [NUM_COEF];
  logic signed [COEF_W-1:0] coef_d [NUM_COEF];
  logic signed [DATA_W-1:0] x1_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0] x1_d [NUM_SECTIONS];
  logic signed [DATA_W-1:0] x2_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0] x2_d [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y1_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y1_d [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y2_q [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y2_d [NUM_SECTIONS];
  logic signed [DATA_W-1:0] y_out_q, y_out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     in_ready_q;
  logic                     cfg_err_q, cfg_err_d;
  logic                     sat_q, sat_d;

  logic                     cfg_ok_s;
  logic [ADDR_W-1:0]        coef_idx_s;
  logic signed [COEF_W-1:0] coef_s;
  logic signed [DATA_W-1:0] data_s;
  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [DATA_W-1:0] y_sat_s;
  logic                     clip_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign y_out     = y_out_q;
  assign cfg_err   = cfg_err_q;
  assign sat_flag  = sat_q;

  // Writes land only while idle so a running sample never sees a torn coefficient set.
  assign cfg_ok_s   = (state_q == ST_IDLE) && ({1'b0, cfg_addr} < NUM_COEF_A);
  assign coef_idx_s = ADDR_W'(sec_q) * ADDR_W'(TAPS_PER_SECTION) + ADDR_W'(tap_q);
  assign coef_s     = coef_q[coef_idx_s];

  // Select the data operand paired with the current tap.
  always_comb begin
    data_s = {DATA_W{1'b0}};
    case (tap_q)
      TAP_B0:  data_s = cur_x_q;
      TAP_B1:  data_s = x1_q[sec_q];
      TAP_B2:  data_s = x2_q[sec_q];
      TAP_A1:  data_s = y1_q[sec_q];
      TAP_A2:  data_s = y2_q[sec_q];
      default: data_s = {DATA_W{1'b0}};
    endcase
  end

  // Full-precision signed product, sign-extended into the accumulator width.
  always_comb begin
    prod_s     = $signed({{DATA_W{coef_s[COEF_W-1]}}, coef_s}) *
                 $signed({{COEF_W{data_s[DATA_W-1]}}, data_s});
    prod_ext_s = {{(ACC_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end

  iir_round_sat #(
    .DATA_W    (DATA_W),
    .COEF_FRAC (COEF_FRAC),
    .ACC_W     (ACC_W)
  ) u_round_sat (
    .acc_i  (acc_q),
    .y_o    (y_sat_s),
    .clip_o (clip_s)
  );

  // Sequencer next-state, datapath updates and configuration handling.
  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    sec_d       = sec_q;
    acc_d       = acc_q;
    cur_x_d     = cur_x_q;
    coef_d      = coef_q;
    x1_d        = x1_q;
    x2_d        = x2_q;
    y1_d        = y1_q;
    y2_d        = y2_q;
    y_out_d     = y_out_q;
    sat_d       = sat_q;
    out_valid_d = 1'b0;
    cfg_err_d   = 1'b0;

    if (cfg_we) begin
      if (cfg_ok_s) begin
        coef_d[cfg_addr] = cfg_wdata;
      end else begin
        cfg_err_d = 1'b1;
      end
    end else begin
      cfg_err_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Clear shares the edge with an accepted sample, so that sample starts from zero history.
        if (clear_state) begin
          for (int s = 0; s < NUM_SECTIONS; s++) begin
            x1_d[s] = {DATA_W{1'b0}};
            x2_d[s] = {DATA_W{1'b0}};
            y1_d[s] = {DATA_W{1'b0}};
            y2_d[s] = {DATA_W{1'b0}};
          end
          sat_d = 1'b0;
        end else begin
          sat_d = sat_q;
        end
        if (in_valid) begin
          cur_x_d = x_in;
          sec_d   = {SEC_W{1'b0}};
          tap_d   = TAP_B0;
          acc_d   = {ACC_W{1'b0}};
          state_d = ST_MAC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MAC: begin
        // Feedback taps are subtracted so stored a1/a2 use the textbook sign.
        if (tap_q >= TAP_A1) begin
          acc_d = acc_q - prod_ext_s;
        end else begin
          acc_d = acc_q + prod_ext_s;
        end
        if (tap_q == TAP_A2) begin
          tap_d   = TAP_B0;
          state_d = ST_STORE;
        end else begin
          tap_d   = tap_q + 3'd1;
          state_d = ST_MAC;
        end
      end
      ST_STORE: begin
        x2_d[sec_q] = x1_q[sec_q];
        x1_d[sec_q] = cur_x_q;
        y2_d[sec_q] = y1_q[sec_q];
        y1_d[sec_q] = y_sat_s;
        if (clip_s) begin
          sat_d = 1'b1;
        end else begin
          sat_d = sat_q;
        end
        acc_d = {ACC_W{1'b0}};
        tap_d = TAP_B0;
        // Result is loaded on entry to OUT so it is already stable while out_valid is high.
        if (sec_q == LAST_SEC) begin
          y_out_d     = y_sat_s;
          out_valid_d = 1'b1;
          state_d     = ST_OUT;
        end else begin
          sec_d   = sec_q + SEC_W'(1);
          cur_x_d = y_sat_s;
          state_d = ST_MAC;
        end
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and coefficient registers; reset restores pass-through coefficients.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tap_q       <= TAP_B0;
      sec_q       <= {SEC_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      cur_x_q     <= {DATA_W{1'b0}};
      y_out_q     <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      cfg_err_q   <= 1'b0;
      sat_q       <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        coef_q[i] <= ((i % TAPS_PER_SECTION) == 0) ? COEF_ONE : {COEF_W{1'b0}};
      end
      for (int s = 0; s < NUM_SECTIONS; s++) begin
        x1_q[s] <= {DATA_W{1'b0}};
        x2_q[s] <= {DATA_W{1'b0}};
        y1_q[s] <= {DATA_W{1'b0}};
        y2_q[s] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      sec_q       <= sec_d;
      acc_q       <= acc_d;
      cur_x_q     <= cur_x_d;
      y_out_q     <= y_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= (state_d == ST_IDLE);
      cfg_err_q   <= cfg_err_d;
      sat_q       <= sat_d;
      coef_q      <= coef_d;
      x1_q        <= x1_d;
      x2_q        <= x2_d;
      y1_q        <= y1_d;
      y2_q        <= y2_d;
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Self-checking bench: a sample-level arithmetic model of the cascade plus a
// timing model (busy countdown), compared against the DUT on every cycle,
// with hand-computed literal expectations for the directed scenarios.
module tb_iir_biquad_cascade;

  localparam int DW  = 16;
  localparam int CW  = 16;
  localparam int FR  = 14;
  localparam int NS  = 2;
  localparam int NC  = 5 * NS;
  localparam int AW  = $clog2(NC);
  localparam int LAT = 6 * NS + 1;
  localparam longint YMAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam longint YMIN = -(64'sd1 <<< (DW - 1));

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] x_in;
  logic                 out_valid;
  logic signed [DW-1:0] y_out;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [CW-1:0] cfg_wdata;
  logic                 cfg_err;
  logic                 clear_state;
  logic                 sat_flag;

  int checks = 0;
  int errors = 0;

  // model state
  longint mc [NC];
  longint hx1 [NS];
  longint hx2 [NS];
  longint hy1 [NS];
  longint hy2 [NS];
  bit     msat [NS];
  int     busy;
  longint pend_y;
  longint exp_y;
  bit     exp_sat;
  bit     exp_err;
  bit     started = 1'b0;

  iir_biquad_cascade #(
    .DATA_W       (DW),
    .COEF_W       (CW),
    .COEF_FRAC    (FR),
    .NUM_SECTIONS (NS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .x_in        (x_in),
    .out_valid   (out_valid),
    .y_out       (y_out),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_err     (cfg_err),
    .clear_state (clear_state),
    .sat_flag    (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) mc[i] = ((i % 5) == 0) ? (64'sd1 <<< FR) : 64'sd0;
    for (int s = 0; s < NS; s++) begin
      hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0; msat[s] = 1'b0;
    end
    busy = 0; pend_y = 0; exp_y = 0; exp_sat = 1'b0; exp_err = 1'b0;
  endtask

  // Whole-sample cascade computation in plain integer arithmetic.
  task automatic model_sample(input longint x, output longint y);
    longint v, acc, r;
    v = x;
    for (int s = 0; s < NS; s++) begin
      acc = mc[5*s] * v + mc[5*s+1] * hx1[s] + mc[5*s+2] * hx2[s]
          - mc[5*s+3] * hy1[s] - mc[5*s+4] * hy2[s];
      r = (acc + (64'sd1 <<< (FR - 1))) >>> FR;
      msat[s] = (r > YMAX) || (r < YMIN);
      if (r > YMAX) r = YMAX;
      else if (r < YMIN) r = YMIN;
      hx2[s] = hx1[s]; hx1[s] = v; hy2[s] = hy1[s]; hy1[s] = r;
      v = r;
    end
    y = v;
  endtask

  // Model advance (inputs seen at the last rising edge) and per-cycle compare.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        model_reset();
        started = 1'b1;
      end else if (started) begin
        exp_err = cfg_we && !(busy == 0 && cfg_addr < NC);
        if (busy > 0) begin
          busy--;
          for (int s = 0; s < NS; s++)
            if ((LAT - busy) == 6 * (s + 1) && msat[s]) exp_sat = 1'b1;
          if (busy == 1) exp_y = pend_y;
        end else begin
          if (cfg_we && cfg_addr < NC) mc[cfg_addr] = longint'(cfg_wdata);
          if (clear_state) begin
            for (int s = 0; s < NS; s++) begin
              hx1[s] = 0; hx2[s] = 0; hy1[s] = 0; hy2[s] = 0;
            end
            exp_sat = 1'b0;
          end
          if (in_valid) begin
            model_sample(longint'(x_in), pend_y);
            busy = LAT;
          end
        end
      end
      if (started) begin
        check("in_ready", longint'(in_ready), longint'(busy == 0));
        check("out_valid", longint'(out_valid), longint'(busy == 1));
        check("y_out", longint'(y_out), exp_y);
        check("sat_flag", longint'(sat_flag), longint'(exp_sat));
        check("cfg_err", longint'(cfg_err), longint'(exp_err));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin
      step();
      n++;
    end
    check("idle_wait", longint'(in_ready), 64'sd1);
  endtask

  task automatic wr(input int addr, input int data);
    wait_idle();
    cfg_we = 1'b1; cfg_addr = AW'(addr); cfg_wdata = CW'(data);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic do_clear();
    wait_idle();
    clear_state = 1'b1;
    step();
    clear_state = 1'b0;
  endtask

  task automatic send(input int x, input longint expv, input string name);
    int n;
    wait_idle();
    in_valid = 1'b1; x_in = DW'(x);
    step();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({name, "_latency"}, n, LAT);
    check({name, "_y"}, longint'(y_out), expv);
    check({name, "_model"}, exp_y, expv);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int acc_cnt;
    int seen;
    rst = 1'b1; in_valid = 1'b0; x_in = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_wdata = '0; clear_state = 1'b0;
    step(); step(); step();
    rst = 1'b0;
    step();
    check("rst_in_ready", longint'(in_ready), 64'sd1);
    check("rst_out_valid", longint'(out_valid), 64'sd0);
    check("rst_y_out", longint'(y_out), 64'sd0);
    check("rst_sat", longint'(sat_flag), 64'sd0);
    check("rst_cfg_err", longint'(cfg_err), 64'sd0);

    // pass-through after reset
    send(1000, 1000, "pass");
    check("pass_sat", longint'(sat_flag), 64'sd0);

    // gain 0.5 in section 0, round half-up
    wr(0, 8192);
    send(1000, 500, "half_1000");
    send(3, 2, "half_p3");
    send(-3, -1, "half_m3");

    // first-order recursion y = x + 0.5*y1
    wr(0, 16384);
    wr(3, -8192);
    do_clear();
    send(16384, 16384, "rec0");
    send(0, 8192, "rec1");
    send(0, 4096, "rec2");
    send(0, 2048, "rec3");
    do_clear();
    send(0, 0, "rec_clr");

    // saturation, sticky flag
    wr(3, 0);
    wr(0, 32767);
    send(30000, 32767, "sat_pos");
    check("sat_set", longint'(sat_flag), 64'sd1);
    send(100, 200, "sat_mid");
    check("sat_sticky", longint'(sat_flag), 64'sd1);
    send(-30000, -32768, "sat_neg");

    // in_valid held 40 cycles -> 3 accepted
    wr(0, 16384);
    wait_idle();
    acc_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid = 1'b1;
      x_in = DW'($urandom);
      if (in_ready) acc_cnt++;
      step();
    end
    in_valid = 1'b0;
    check("hold_accepts", acc_cnt, 3);

    // write while busy is rejected
    wait_idle();
    in_valid = 1'b1; x_in = DW'(5);
    step();
    in_valid = 1'b0;
    step();
    cfg_we = 1'b1; cfg_addr = AW'(0); cfg_wdata = CW'(1234);
    step();
    cfg_we = 1'b0;
    check("cfg_err_busy", longint'(cfg_err), 64'sd1);
    step();
    check("cfg_err_pulse", longint'(cfg_err), 64'sd0);
    send(1000, 1000, "busy_unchanged");

    // out-of-range address in IDLE
    wr(10, 5);
    check("cfg_err_range", longint'(cfg_err), 64'sd1);

    // reset mid-operation
    wr(0, 8192);
    wait_idle();
    in_valid = 1'b1; x_in = DW'(1000);
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) seen++;
      step();
    end
    check("abort_no_out", seen, 0);
    check("abort_ready", longint'(in_ready), 64'sd1);
    send(1000, 1000, "abort_restored");

    // randomized traffic against the model
    for (int c = 0; c < 900; c++) begin
      in_valid    = ($urandom_range(2) == 0);
      x_in        = DW'($urandom);
      cfg_we      = ($urandom_range(7) == 0);
      cfg_addr    = AW'($urandom_range(15));
      cfg_wdata   = CW'($urandom_range(32767) - 16384);
      clear_state = ($urandom_range(15) == 0);
      step();
    end
    in_valid = 1'b0; cfg_we = 1'b0; clear_state = 1'b0;
    wait_idle();
    step(); step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
